// File: rtl/vend_coin_sched.sv
// Coin-slot front end for the vending seller: round-robin grant of one coin per
// transaction, seller response capture, and one-at-a-time $1 change payout.
module vend_coin_sched #(
  parameter int GAP_CYCLES  = 2,
  parameter int HOP_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_one,
  input  logic             req_two,
  input  logic             req_five,
  output logic             ack_one,
  output logic             ack_two,
  output logic             ack_five,
  output logic             one,
  output logic             two,
  output logic             five,
  input  logic             goods_i,
  input  logic [2:0]       change_i,
  output logic             vend,
  output logic             hop_req,
  input  logic             hop_ack,
  output logic             hop_err,
  output logic             busy,
  output logic [CNT_W-1:0] sales
);

  localparam int TW = (HOP_TIMEOUT > 1) ? $clog2(HOP_TIMEOUT + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_PAY, S_PAY_GAP, S_GAP
  } state_e;

  localparam logic [1:0] SL_ONE  = 2'd0;
  localparam logic [1:0] SL_TWO  = 2'd1;
  localparam logic [1:0] SL_FIVE = 2'd2;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [2:0]       pay_q, pay_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             vend_q, vend_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] sales_q, sales_d;
  logic [2:0]       req_vec;

  function automatic logic [1:0] next_slot(input logic [1:0] s);
    next_slot = (s == SL_FIVE) ? SL_ONE : s + 2'd1;
  endfunction

  // First requesting slot at or after the pointer, wrapping ONE -> TWO -> FIVE.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [2:0] req);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    idx     = ptr;
    found   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
      idx = next_slot(idx);
    end
  endfunction

  assign req_vec = {req_five, req_two, req_one};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= SL_ONE;
      ptr_q   <= SL_ONE;
      pay_q   <= '0;
      timer_q <= '0;
      gap_q   <= '0;
      vend_q  <= 1'b0;
      err_q   <= 1'b0;
      sales_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      pay_q   <= pay_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      vend_q  <= vend_d;
      err_q   <= err_d;
      sales_q <= sales_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    pay_d   = pay_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    vend_d  = 1'b0;
    err_d   = err_q;
    sales_d = sales_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req_vec) begin
          grant_d = rr_pick(ptr_q, req_vec);
          ptr_d   = next_slot(grant_d);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Seller response is combinational off our pulse, so it is valid now.
        vend_d = goods_i;
        if (goods_i) sales_d = sales_q + 1'b1;
        if (change_i != 3'd0) begin
          pay_d   = change_i;
          timer_d = '0;
          state_d = S_PAY;
        end else begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_PAY: begin
        if (hop_ack) begin
          pay_d   = pay_q - 3'd1;
          timer_d = '0;
          if (pay_q == 3'd1) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            state_d = S_PAY_GAP;
          end
        end else if (timer_q == TW'(HOP_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          pay_d   = '0;
          timer_d = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_PAY_GAP: begin
        timer_d = '0;
        state_d = S_PAY;
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from registers so reset clears them immediately.
  assign one      = (state_q == S_ISSUE) && (grant_q == SL_ONE);
  assign two      = (state_q == S_ISSUE) && (grant_q == SL_TWO);
  assign five     = (state_q == S_ISSUE) && (grant_q == SL_FIVE);
  assign ack_one  = one;
  assign ack_two  = two;
  assign ack_five = five;
  assign hop_req  = (state_q == S_PAY);
  assign busy     = (state_q != S_IDLE);
  assign vend     = vend_q;
  assign hop_err  = err_q;
  assign sales    = sales_q;

endmodule

// File: tb/tb_vend_coin_sched.sv
// Directed bench for vend_coin_sched: seller and hopper models, invariant monitor,
// hand-computed expectations checked through a single chk task.
module tb_vend_coin_sched;

  localparam int GAP = 2;
  localparam int HT  = 255;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_one, req_two, req_five;
  logic          ack_one, ack_two, ack_five;
  logic          one, two, five;
  logic          goods_i;
  logic [2:0]    change_i;
  logic          vend, hop_req, hop_ack, hop_err, busy;
  logic [CW-1:0] sales;

  logic          s_goods;
  logic [2:0]    s_change;
  logic          hop_en;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0, viol = 0;
  int n_one = 0, n_ack1 = 0, n_vend = 0, n_hop_rise = 0, n_hop_hi = 0;
  int hcnt = 0;
  logic prev_pulse = 1'b0, prev_hop = 1'b0;

  always #5 clk = ~clk;

  // Seller answers combinationally during the coin pulse.
  assign goods_i  = (one | two | five) ? s_goods  : 1'b0;
  assign change_i = (one | two | five) ? s_change : 3'd0;

  vend_coin_sched #(.GAP_CYCLES(GAP), .HOP_TIMEOUT(HT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_one(req_one), .req_two(req_two), .req_five(req_five),
    .ack_one(ack_one), .ack_two(ack_two), .ack_five(ack_five),
    .one(one), .two(two), .five(five),
    .goods_i(goods_i), .change_i(change_i),
    .vend(vend), .hop_req(hop_req), .hop_ack(hop_ack), .hop_err(hop_err),
    .busy(busy), .sales(sales)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor and hopper model; hopper acks in the third cycle of each request.
  initial begin
    hop_ack = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if ($countones({five, two, one}) > 1) viol++;
      if ({ack_five, ack_two, ack_one} != {five, two, one}) viol++;
      if (prev_pulse && (one | two | five)) viol++;
      if (!busy && (one | two | five | hop_req | vend)) viol++;
      prev_pulse = one | two | five;
      n_one  += int'(one);
      n_ack1 += int'(ack_one);
      n_vend += int'(vend);
      if (hop_req && !prev_hop) n_hop_rise++;
      if (hop_req) n_hop_hi++;
      prev_hop = hop_req;
      if (rst || !hop_req) hcnt = 0;
      else hcnt++;
      hop_ack = hop_en && hop_req && (hcnt == 3);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_pulse(output logic [2:0] p);
    p = 3'b000;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      p = {five, two, one};
      if (p != 3'b000) break;
    end
    if (p == 3'b000) chk("pulse_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      if (!busy) break;
      tick(1);
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  logic [2:0] p;
  logic [2:0] t2_exp [3] = '{3'b001, 3'b010, 3'b100};
  logic [1:0] t6_exp [3] = '{2'd3, 2'd0, 2'd1};
  int last, h0, hh0, v0, o0, a0, cnt;

  initial begin
    rst = 1'b1;
    req_one = 1'b0; req_two = 1'b0; req_five = 1'b0;
    s_goods = 1'b0; s_change = 3'd0; hop_en = 1'b0;
    tick(2);
    chk("reset_outputs", {one, two, five, ack_one, ack_two, ack_five, vend, hop_req, hop_err, busy}, 0);
    chk("reset_sales", sales, 0);
    rst = 1'b0;
    tick(1);

    // 1: single $2 coin, no goods, no change
    req_two = 1'b1;
    wait_pulse(p);
    chk("t1_pulse", p, 3'b010);
    chk("t1_ack_two", ack_two, 1);
    req_two = 1'b0;
    tick(1);
    chk("t1_ack_single", {ack_one, ack_two, ack_five}, 0);
    chk("t1_no_vend", vend, 0);
    chk("t1_no_hop", hop_req, 0);
    chk("t1_busy_gap1", busy, 1);
    tick(1);
    chk("t1_busy_gap2", busy, 1);
    tick(1);
    chk("t1_idle", busy, 0);

    // 2: all three held, RR order and spacing
    do_reset();
    req_one = 1'b1; req_two = 1'b1; req_five = 1'b1;
    last = 0;
    for (int k = 0; k < 3; k++) begin
      wait_pulse(p);
      chk("t2_order", p, t2_exp[k]);
      if (k > 0) chk("t2_spacing", cyc - last, 2 + GAP);
      last = cyc;
      if (p[0]) req_one = 1'b0;
      if (p[1]) req_two = 1'b0;
      if (p[2]) req_five = 1'b0;
    end
    wait_idle(20);

    // 3: $5 with goods and 3 coins change
    do_reset();
    s_goods = 1'b1; s_change = 3'd3; hop_en = 1'b1;
    h0 = n_hop_rise; hh0 = n_hop_hi; v0 = n_vend;
    req_five = 1'b1;
    wait_pulse(p);
    chk("t3_pulse", p, 3'b100);
    chk("t3_sales_before", sales, 0);
    req_five = 1'b0;
    tick(1);
    chk("t3_vend", vend, 1);
    chk("t3_sales_after", sales, 1);
    tick(1);
    chk("t3_vend_single", vend, 0);
    wait_idle(60);
    chk("t3_hop_phases", n_hop_rise - h0, 3);
    chk("t3_hop_cycles", n_hop_hi - hh0, 9);
    chk("t3_vend_count", n_vend - v0, 1);
    chk("t3_no_err", hop_err, 0);

    // 4: hopper silent -> timeout
    s_goods = 1'b0; s_change = 3'd2; hop_en = 1'b0;
    req_one = 1'b1;
    wait_pulse(p);
    chk("t4_pulse", p, 3'b001);
    req_one = 1'b0;
    tick(1);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hop_req) break;
      cnt++;
      tick(1);
    end
    chk("t4_hop_cycles", cnt, HT);
    chk("t4_err", hop_err, 1);
    wait_idle(10);
    s_goods = 1'b1; s_change = 3'd0;
    req_one = 1'b1;
    wait_pulse(p);
    chk("t4_accept", p, 3'b001);
    req_one = 1'b0;
    tick(1);
    chk("t4_sales", sales, 2);
    chk("t4_err_sticky", hop_err, 1);
    wait_idle(10);

    // 6: sales wrap at CNT_W=2; short req while busy is dropped
    o0 = n_one; a0 = n_ack1;
    for (int k = 0; k < 3; k++) begin
      req_five = 1'b1;
      wait_pulse(p);
      req_five = 1'b0;
      tick(1);
      chk("t6_sales", sales, t6_exp[k]);
      if (k == 0) begin
        req_one = 1'b1;
        tick(1);
        req_one = 1'b0;
      end
      wait_idle(20);
    end
    tick(4);
    chk("t6_dropped_pulse", n_one - o0, 0);
    chk("t6_dropped_ack", n_ack1 - a0, 0);

    // 5: reset during payout
    s_goods = 1'b1; s_change = 3'd2; hop_en = 1'b0;
    req_two = 1'b1;
    wait_pulse(p);
    req_two = 1'b0;
    tick(3);
    chk("t5_in_pay", hop_req, 1);
    rst = 1'b1;
    #1;
    chk("t5_hop_async", hop_req, 0);
    chk("t5_outputs", {one, two, five, vend, hop_err, busy}, 0);
    chk("t5_sales", sales, 0);
    tick(1);
    rst = 1'b0;
    s_goods = 1'b0; s_change = 3'd0;
    req_two = 1'b1; req_five = 1'b1;
    wait_pulse(p);
    chk("t5_ptr_one", p, 3'b010);
    req_two = 1'b0;
    wait_idle(20);
    wait_pulse(p);
    chk("t5_next_five", p, 3'b100);
    req_five = 1'b0;
    wait_idle(20);

    chk("invariants", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
